// File: rtl/contador_prescaler_if.sv
// contador_prescaler_if
// ---------------------
// Groups the control inputs and result outputs of contador_prescaler.
// The block has no valid/ready handshake. en and dir are levels.
// carga is a one-cycle strobe: it is acted on at every rising edge where it is high.
// All three outputs are registered levels that are valid every cycle after reset.
//
// Signals:
//   en             master -> slave  counter advance enable
//   carga          master -> slave  synchronous load strobe
//   valor_carga    master -> slave  load value, W bits
//   dir            master -> slave  0 = up, 1 = down (CONTADOR_DIR_EN builds only)
//   Hz             slave -> master  divided clock
//   contagem       slave -> master  counter value, W bits
//   saida_contador slave -> master  terminal-count level
// Modports: master (stimulus side), slave (contador_prescaler).
interface contador_prescaler_if #(
  parameter int W = 4
);
  logic         en;
  logic         carga;
  logic [W-1:0] valor_carga;
  logic         dir;
  logic         Hz;
  logic [W-1:0] contagem;
  logic         saida_contador;

  modport master (
    output en, carga, valor_carga, dir,
    input  Hz, contagem, saida_contador
  );

  modport slave (
    input  en, carga, valor_carga, dir,
    output Hz, contagem, saida_contador
  );
endinterface

// File: rtl/contador_prescaler.sv
// contador_prescaler
// ------------------
// A free-running prescaler divides clk by DIV and produces the square wave Hz.
// Hz is low for DIV/2 cycles and high for the rest of each period.
// contagem is a loadable modulo-MOD counter. It steps once per Hz period, on the
// edge where Hz falls, but only when en is high on that edge.
// saida_contador is a registered level. It is high while contagem equals the
// terminal value.
//
// Parameters: DIV (>= 2) prescaler ratio, MOD (>= 2) counter modulus,
//             W counter width (2**W >= MOD).
// Ports:      clk, rst (synchronous, active high),
//             bus (contador_prescaler_if.slave): en, carga, valor_carga, dir -> Hz,
//             contagem, saida_contador.
// Build option: define CONTADOR_DIR_EN to enable down counting via dir.
//               Without it, dir is ignored and the counter only counts up.
module contador_prescaler #(
  parameter int DIV = 50,
  parameter int MOD = 10,
  parameter int W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  contador_prescaler_if.slave    bus
);

  localparam int            PW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
  localparam logic [W-1:0]  C_LAST = W'(MOD - 1);
  localparam logic [W:0]    C_MOD  = (W + 1)'(MOD);

  logic [PW-1:0] p_q, p_d;
  logic          hz_q, hz_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic          sc_q, sc_d;
  logic          tick;
  logic [W-1:0]  load_val;
  logic [W-1:0]  term;

  // Prescaler and Hz.
  // Hz is decoded from the next p, so the Hz flop always equals (p >= DIV/2).
  always_comb begin
    p_d  = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    hz_d = (p_d >= P_HALF);
    tick = (p_q == P_LAST) && bus.en;
  end

  // Load value saturates at MOD-1.
  // One extra bit keeps the compare correct when MOD == 2**W.
  always_comb begin
    load_val = bus.valor_carga;
    if ({1'b0, bus.valor_carga} >= C_MOD) load_val = C_LAST;
  end

`ifdef CONTADOR_DIR_EN
  always_comb begin
    cnt_d = cnt_q;
    if (bus.carga) begin
      cnt_d = load_val;
    end else if (tick) begin
      if (bus.dir) cnt_d = (cnt_q == '0) ? C_LAST : cnt_q - 1'b1;
      else         cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
    term = bus.dir ? '0 : C_LAST;
  end
`else
  // dir is kept on the port list so the wiring is the same in both builds.
  logic dir_unused;
  assign dir_unused = bus.dir;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.carga)  cnt_d = load_val;
    else if (tick)  cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    term = C_LAST;
  end
`endif

  // saida_contador is decoded from the next count value.
  // This makes it change on the same edge as contagem, never one cycle later.
  always_comb begin
    sc_d = (cnt_d == term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      hz_q  <= 1'b0;
      cnt_q <= '0;
      sc_q  <= 1'b0;
    end else begin
      p_q   <= p_d;
      hz_q  <= hz_d;
      cnt_q <= cnt_d;
      sc_q  <= sc_d;
    end
  end

  assign bus.Hz             = hz_q;
  assign bus.contagem       = cnt_q;
  assign bus.saida_contador = sc_q;

endmodule

// File: tb/tb_contador_prescaler.sv
module tb_contador_prescaler;

  localparam int DIV = 4;
  localparam int MOD = 10;
  localparam int W   = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  contador_prescaler_if #(.W(W)) bus ();

  contador_prescaler #(.DIV(DIV), .MOD(MOD), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef CONTADOR_DIR_EN
  localparam bit DIR_BUILD = 1'b1;
`else
  localparam bit DIR_BUILD = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Written from the behavioural rules:
  //   m_ph  = number of edges since reset, taken modulo DIV.
  //   m_cnt = integer taken modulo MOD.
  //   Hz    = (phase >= DIV/2).
  //   The terminal flag compares the new count with MOD-1 (up) or 0 (down).
  int m_ph;
  int m_cnt;
  bit m_sc;
  logic [W+1:0] exp_q[$];

  initial begin
    m_ph  = 0;
    m_cnt = 0;
    m_sc  = 0;
  end

  always @(posedge clk) begin
    bit down;
    bit stepping;
    down     = DIR_BUILD && bus.dir;
    stepping = (m_ph == DIV - 1) && bus.en;
    if (rst) begin
      m_ph  = 0;
      m_cnt = 0;
      m_sc  = 0;
    end else begin
      m_ph = (m_ph + 1) % DIV;
      if (bus.carga)
        m_cnt = (int'(bus.valor_carga) >= MOD) ? MOD - 1 : int'(bus.valor_carga);
      else if (stepping)
        m_cnt = down ? (m_cnt + MOD - 1) % MOD : (m_cnt + 1) % MOD;
      m_sc = (m_cnt == (down ? 0 : MOD - 1));
    end
    exp_q.push_back({m_sc, (m_ph >= DIV / 2), W'(m_cnt)});
  end

  // Scoreboard: every expected entry is compared on the falling edge.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("sb_hz",  int'(bus.Hz),             int'(e[W]));
      check_eq("sb_cnt", int'(bus.contagem),       int'(e[W-1:0]));
      check_eq("sb_sc",  int'(bus.saida_contador), int'(e[W+1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.carga       = 1'b1;
    bus.valor_carga = v;
    step();
    bus.carga       = 1'b0;
  endtask

  // Advance until the model prescaler phase equals ph (bounded).
  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while (m_ph != ph && k < 2 * DIV) begin
      step();
      k++;
    end
    if (m_ph != ph) check_eq("align_timeout", m_ph, ph);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int held;
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b1;
    bus.en          = 1'b1;
    bus.carga       = 1'b0;
    bus.valor_carga = '0;
    bus.dir         = 1'b0;

    // 1. Reset for 2 cycles, then free-run: expect a full counter cycle in 40 edges.
    repeat (2) step();
    check_eq("rst_hz",  int'(bus.Hz), 0);
    check_eq("rst_cnt", int'(bus.contagem), 0);
    check_eq("rst_sc",  int'(bus.saida_contador), 0);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      check_eq("run_hz",  int'(bus.Hz), ((i % 4) >= 2) ? 1 : 0);
      check_eq("run_cnt", int'(bus.contagem), (i / 4) % 10);
      check_eq("run_sc",  int'(bus.saida_contador), (i >= 36 && i <= 39) ? 1 : 0);
    end

    // 2. Load a legal value, then an out-of-range value that must clamp.
    load(4'd7);
    check_eq("load7_cnt", int'(bus.contagem), 7);
    check_eq("load7_sc",  int'(bus.saida_contador), 0);
    load(4'd13);
    check_eq("clamp_cnt", int'(bus.contagem), 9);
    check_eq("clamp_sc",  int'(bus.saida_contador), 1);

    // 3. A load on a tick edge wins; the next step comes 4 clocks later.
    wait_phase(DIV - 1);
    load(4'd3);
    check_eq("coll_cnt", int'(bus.contagem), 3);
    repeat (3) step();
    check_eq("coll_hold", int'(bus.contagem), 3);
    step();
    check_eq("coll_step", int'(bus.contagem), 4);

    // 4. en = 0 for 12 clocks freezes contagem. A single en pulse at p = 1 does nothing.
    bus.en = 1'b0;
    held = int'(bus.contagem);
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("gate_cnt", int'(bus.contagem), held);
    end
    wait_phase(1);
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    repeat (8) step();
    check_eq("pulse_cnt", int'(bus.contagem), held);

    // 5. Down mode from 1 (in the up-only build this counts 1 -> 2 -> 3).
    bus.dir = 1'b1;
    load(4'd1);
    bus.en = 1'b1;
    wait_phase(DIV - 1);
    step();
    check_eq("dir1_cnt", int'(bus.contagem), DIR_BUILD ? 0 : 2);
    check_eq("dir1_sc",  int'(bus.saida_contador), DIR_BUILD ? 1 : 0);
    repeat (DIV) step();
    check_eq("dir2_cnt", int'(bus.contagem), DIR_BUILD ? 9 : 3);
    check_eq("dir2_sc",  int'(bus.saida_contador), 0);
    bus.dir = 1'b0;

    // 6. Reset at contagem = 5, p = 2. The first step after release comes 4 edges later.
    bus.en = 1'b0;
    load(4'd5);
    wait_phase(2);
    check_eq("pre_rst_cnt", int'(bus.contagem), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.en = 1'b1;
    check_eq("mrst_hz",  int'(bus.Hz), 0);
    check_eq("mrst_cnt", int'(bus.contagem), 0);
    check_eq("mrst_sc",  int'(bus.saida_contador), 0);
    repeat (3) step();
    check_eq("mrst_hold", int'(bus.contagem), 0);
    step();
    check_eq("mrst_step", int'(bus.contagem), 1);

    // 7. Random traffic, checked only by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 99) < 2);
      bus.en          = ($urandom_range(0, 3) != 0);
      bus.carga       = ($urandom_range(0, 14) == 0);
      bus.valor_carga = W'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bus.dir = ~bus.dir;
      step();
    end
    rst       = 1'b0;
    bus.carga = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
